// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: load-use interlock,
// multi-cycle MUL in EX, MA-stage memory handshake and wrong-path squash.
module pipe_hazard_ctrl #(
   parameter int unsigned MUL_LAT = 3,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_valid,
   input  logic [4:0]       ex_rd,
   input  logic             ex_is_load,
   input  logic             ex_is_mul,
   input  logic             ex_redirect,
   input  logic             ma_valid,
   input  logic             ma_mem_read,
   input  logic             ma_mem_write,
   input  logic             Mem_Req_Ready,
   input  logic             Read_data_Valid,
   output logic             Mem_Req_Valid,
   output logic             Read_data_Ready,
   output logic             hold_if,
   output logic             hold_id,
   output logic             hold_ex,
   output logic             hold_ma,
   output logic             bubble_ex,
   output logic             flush_id,
   output logic             mul_busy,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic [1:0] {MEM_IDLE, MEM_REQ, MEM_RDW, MEM_DONE} mem_state_e;

   localparam logic [3:0] MUL_INIT  = 4'(MUL_LAT - 1);
   localparam logic       MUL_MULTI = (MUL_LAT > 1);

   mem_state_e       mem_state_q, mem_state_d;
   logic [3:0]       mul_cnt_q, mul_cnt_d;
   logic [CNT_W-1:0] stall_q, stall_d;

   logic active;
   logic mem_access;
   logic mem_hold;
   logic mul_load;
   logic mul_busy_c;
   logic mul_stall;
   logic redirect;
   logic load_use;

   assign active     = ~rst;
   assign mem_access = ma_valid & (ma_mem_read | ma_mem_write);

   always_comb begin
      mem_state_d = mem_state_q;
      case (mem_state_q)
         MEM_IDLE: if (mem_access)      mem_state_d = MEM_REQ;
         MEM_REQ:  if (Mem_Req_Ready)   mem_state_d = ma_mem_read ? MEM_RDW : MEM_DONE;
         MEM_RDW:  if (Read_data_Valid) mem_state_d = MEM_DONE;
         MEM_DONE:                      mem_state_d = MEM_IDLE;
         default:                       mem_state_d = MEM_IDLE;
      endcase
   end

   assign mem_hold = active & (((mem_state_q == MEM_IDLE) & mem_access) |
                               (mem_state_q == MEM_REQ) | (mem_state_q == MEM_RDW));

   assign mul_load   = active & MUL_MULTI & ex_valid & ex_is_mul &
                       (mul_cnt_q == 4'd0) & ~mem_hold;
   assign mul_busy_c = active & ((mul_cnt_q != 4'd0) | mul_load);
   // The final MUL cycle (counter at 1) releases EX so the result moves on.
   assign mul_stall  = mul_load | (mul_cnt_q > 4'd1);

   assign redirect = active & ex_valid & ex_redirect;
   assign load_use = active & ex_valid & ex_is_load & (ex_rd != 5'd0) & id_valid &
                     ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

   always_comb begin
      hold_if   = 1'b0;
      hold_id   = 1'b0;
      hold_ex   = 1'b0;
      hold_ma   = 1'b0;
      bubble_ex = 1'b0;
      flush_id  = 1'b0;
      if (mem_hold) begin
         hold_if = 1'b1;
         hold_id = 1'b1;
         hold_ex = 1'b1;
         hold_ma = 1'b1;
      end else if (mul_busy_c) begin
         hold_if = mul_stall;
         hold_id = mul_stall;
         hold_ex = mul_stall;
      end else if (redirect) begin
         flush_id  = 1'b1;
         bubble_ex = 1'b1;
      end else if (load_use) begin
         hold_if   = 1'b1;
         hold_id   = 1'b1;
         bubble_ex = 1'b1;
      end
   end

   assign Mem_Req_Valid   = active & (mem_state_q == MEM_REQ);
   assign Read_data_Ready = active & (mem_state_q == MEM_RDW);
   assign mul_busy        = mul_busy_c;
   assign stall_cycles    = stall_q;

   always_comb begin
      mul_cnt_d = mul_cnt_q;
      if (mul_load)
         mul_cnt_d = MUL_INIT;
      else if ((mul_cnt_q != 4'd0) & ~mem_hold)
         mul_cnt_d = mul_cnt_q - 4'd1;
   end

   // Saturates rather than wrapping so long runs never report a small count.
   assign stall_d = (hold_if && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_state_q <= MEM_IDLE;
         mul_cnt_q   <= 4'd0;
         stall_q     <= '0;
      end else begin
         mem_state_q <= mem_state_d;
         mul_cnt_q   <= mul_cnt_d;
         stall_q     <= stall_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed pipeline scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_pipe_hazard_ctrl;
   localparam int unsigned MUL_LAT = 3;
   localparam int unsigned CNT_W   = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic id_valid = 0, id_use_rs1 = 0, id_use_rs2 = 0;
   logic [4:0] id_rs1 = 0, id_rs2 = 0, ex_rd = 0;
   logic ex_valid = 0, ex_is_load = 0, ex_is_mul = 0, ex_redirect = 0;
   logic ma_valid = 0, ma_mem_read = 0, ma_mem_write = 0;
   logic Mem_Req_Ready = 0, Read_data_Valid = 0;
   logic Mem_Req_Valid, Read_data_Ready, hold_if, hold_id, hold_ex, hold_ma;
   logic bubble_ex, flush_id, mul_busy;
   logic [CNT_W-1:0] stall_cycles;

   pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
      .ex_is_mul(ex_is_mul), .ex_redirect(ex_redirect),
      .ma_valid(ma_valid), .ma_mem_read(ma_mem_read), .ma_mem_write(ma_mem_write),
      .Mem_Req_Ready(Mem_Req_Ready), .Read_data_Valid(Read_data_Valid),
      .Mem_Req_Valid(Mem_Req_Valid), .Read_data_Ready(Read_data_Ready),
      .hold_if(hold_if), .hold_id(hold_id), .hold_ex(hold_ex), .hold_ma(hold_ma),
      .bubble_ex(bubble_ex), .flush_id(flush_id), .mul_busy(mul_busy),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: memory transaction phase as flags, MUL as cycles spent in EX.
   bit req_out, data_out, retire;
   int mul_done;
   logic [CNT_W-1:0] m_stalls;
   bit e_mhold, e_busy, e_hold_if;
   logic [8:0] e_outs, obs_outs;
   int cnt_mrv, cnt_rdr, cnt_hold, cnt_hex, cnt_hma, cnt_busy, cnt_flush;

   task automatic model_eval();
      bit access, start, stall_mul, redir, lu;
      bit hif, hid, hex, hma, bub, fl;
      {hif, hid, hex, hma, bub, fl} = '0;
      e_mhold = 0; e_busy = 0;
      e_outs = '0;
      if (!rst) begin
         access    = ma_valid && (ma_mem_read || ma_mem_write);
         e_mhold   = req_out || data_out || (!retire && access);
         start     = !e_mhold && mul_done == 0 && ex_valid && ex_is_mul && MUL_LAT > 1;
         e_busy    = (mul_done > 0) || start;
         stall_mul = e_busy && (mul_done + 1 < MUL_LAT);
         redir     = ex_valid && ex_redirect;
         lu        = ex_valid && ex_is_load && ex_rd != 0 && id_valid &&
                     ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
         if (e_mhold)     {hif, hid, hex, hma} = 4'b1111;
         else if (e_busy) {hif, hid, hex} = {3{stall_mul}};
         else if (redir)  {fl, bub} = 2'b11;
         else if (lu)     {hif, hid, bub} = 3'b111;
         e_outs = {req_out, data_out, hif, hid, hex, hma, bub, fl, e_busy};
      end
      e_hold_if = hif;
   endtask

   task automatic model_update();
      if (rst) begin
         req_out = 0; data_out = 0; retire = 0; mul_done = 0; m_stalls = '0;
      end else begin
         if (e_hold_if && m_stalls != '1) m_stalls = m_stalls + 1;
         if (!e_mhold && e_busy) begin
            mul_done++;
            if (mul_done == MUL_LAT) mul_done = 0;
         end
         if (retire) retire = 0;
         else if (req_out) begin
            if (Mem_Req_Ready) begin
               req_out = 0;
               if (ma_mem_read) data_out = 1;
               else retire = 1;
            end
         end else if (data_out) begin
            if (Read_data_Valid) begin data_out = 0; retire = 1; end
         end else if (ma_valid && (ma_mem_read || ma_mem_write)) req_out = 1;
      end
   endtask

   task automatic step();
      @(negedge clk);
      model_eval();
      obs_outs = {Mem_Req_Valid, Read_data_Ready, hold_if, hold_id, hold_ex,
                  hold_ma, bubble_ex, flush_id, mul_busy};
      chk("outs", obs_outs, e_outs);
      chk("stall_cycles", stall_cycles, m_stalls);
      cnt_mrv += int'(Mem_Req_Valid); cnt_rdr += int'(Read_data_Ready);
      cnt_hold += int'(hold_if); cnt_hex += int'(hold_ex); cnt_hma += int'(hold_ma);
      cnt_busy += int'(mul_busy); cnt_flush += int'(flush_id);
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic clr_counts();
      {cnt_mrv, cnt_rdr, cnt_hold, cnt_hex, cnt_hma, cnt_busy, cnt_flush} = '0;
   endtask

   task automatic idle_inputs();
      id_valid = 0; id_use_rs1 = 0; id_use_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
      ex_valid = 0; ex_rd = 0; ex_is_load = 0; ex_is_mul = 0; ex_redirect = 0;
      ma_valid = 0; ma_mem_read = 0; ma_mem_write = 0;
      Mem_Req_Ready = 0; Read_data_Valid = 0;
   endtask

   logic [CNT_W-1:0] s0;
   int kind;

   initial begin
      idle_inputs();
      rst = 1;
      step();
      chk("reset_outs", obs_outs, 9'd0);
      step();
      rst = 0;
      step();

      // lw x5 in EX, add x6,x5,x1 in ID
      ex_valid = 1; ex_is_load = 1; ex_rd = 5;
      id_valid = 1; id_rs1 = 5; id_rs2 = 1; id_use_rs1 = 1; id_use_rs2 = 1;
      step();
      chk("lu_outs", obs_outs, 9'b0_0_1_1_0_0_1_0_0);
      idle_inputs();
      step();
      chk("lu_after", obs_outs, 9'd0);
      chk("lu_stalls", stall_cycles, 1);
      $display("[TB] load-use: stall_cycles=%0d", stall_cycles);

      // MUL occupying EX
      s0 = stall_cycles; clr_counts();
      ex_valid = 1; ex_is_mul = 1;
      repeat (MUL_LAT) step();
      idle_inputs();
      step();
      chk("mul_busy_cycles", cnt_busy, MUL_LAT);
      chk("mul_hold_ex_cycles", cnt_hex, MUL_LAT - 1);
      chk("mul_hold_ma_cycles", cnt_hma, 0);
      chk("mul_stalls", stall_cycles - s0, MUL_LAT - 1);
      $display("[TB] mul: busy=%0d hold_ex=%0d", cnt_busy, cnt_hex);

      // Load: ready after 2 cycles, data 3 cycles later
      clr_counts();
      ma_valid = 1; ma_mem_read = 1;
      step(); step();
      Mem_Req_Ready = 1; step();
      Mem_Req_Ready = 0; step(); step();
      Read_data_Valid = 1; step();
      Read_data_Valid = 0; step();
      idle_inputs(); step();
      chk("ld_hold_cycles", cnt_hold, 6);
      chk("ld_req_cycles", cnt_mrv, 2);
      chk("ld_rdw_cycles", cnt_rdr, 3);
      $display("[TB] load access: hold=%0d req=%0d rdw=%0d", cnt_hold, cnt_mrv, cnt_rdr);

      // Store accepted immediately
      clr_counts();
      ma_valid = 1; ma_mem_write = 1; Mem_Req_Ready = 1;
      step(); step();
      Mem_Req_Ready = 0; step();
      idle_inputs(); step();
      chk("st_req_cycles", cnt_mrv, 1);
      chk("st_rdw_cycles", cnt_rdr, 0);
      chk("st_hold_cycles", cnt_hold, 2);
      $display("[TB] store access: hold=%0d req=%0d", cnt_hold, cnt_mrv);

      // Redirect and load-use in the same cycle
      ex_valid = 1; ex_is_load = 1; ex_rd = 5; ex_redirect = 1;
      id_valid = 1; id_rs1 = 5; id_use_rs1 = 1;
      step();
      chk("redir_lu_outs", obs_outs, 9'b0_0_0_0_0_0_1_1_0);
      idle_inputs(); step();

      // Redirect pending behind a store handshake
      clr_counts();
      ma_valid = 1; ma_mem_write = 1; ex_valid = 1; ex_redirect = 1;
      step(); step();
      Mem_Req_Ready = 1; step();
      chk("redir_frozen_flush", cnt_flush, 0);
      Mem_Req_Ready = 0; step();
      chk("redir_done_outs", obs_outs, 9'b0_0_0_0_0_0_1_1_0);
      idle_inputs(); step();
      $display("[TB] redirect behind store: flush released in DONE");

      // Reset while in RDW with the MUL counter loaded
      ex_valid = 1; ex_is_mul = 1; step();
      ma_valid = 1; ma_mem_read = 1; step();
      Mem_Req_Ready = 1; step();
      Mem_Req_Ready = 0; step();
      rst = 1; step();
      chk("rst_during_outs", obs_outs, 9'd0);
      rst = 0; idle_inputs(); step();
      chk("rst_after_outs", obs_outs, 9'd0);
      chk("rst_after_stalls", stall_cycles, 0);
      $display("[TB] reset in RDW: outs=%0h stall_cycles=%0d", obs_outs, stall_cycles);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         rst         = ($urandom_range(0, 199) == 0);
         kind        = $urandom_range(0, 5);
         ex_valid    = ($urandom_range(0, 3) != 0);
         ex_is_load  = (kind < 2);
         ex_is_mul   = (kind == 2);
         ex_redirect = (kind == 3) || (kind < 2 && $urandom_range(0, 7) == 0);
         ex_rd       = 5'($urandom_range(0, 3));
         id_valid    = ($urandom_range(0, 4) != 0);
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         id_use_rs1  = 1'($urandom_range(0, 1));
         id_use_rs2  = 1'($urandom_range(0, 1));
         ma_valid    = ($urandom_range(0, 3) == 0);
         ma_mem_read = 1'($urandom_range(0, 1));
         ma_mem_write = ~ma_mem_read & 1'($urandom_range(0, 1));
         Mem_Req_Ready   = ($urandom_range(0, 2) == 0);
         Read_data_Valid = ($urandom_range(0, 2) == 0);
         step();
      end
      rst = 0;
      idle_inputs();
      step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
